param_alu_unit: RTL and testbench



---
 rtl/param_alu_unit.sv | 185 ++++++++++++++++++
 tb/tb_param_alu_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_alu_unit.sv
// Parameterised integer ALU with a one-cycle path for simple ops and a
// bit-serial signed multiplier, behind a valid/ready handshake with flush.
module param_alu_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_src0,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [5:0]       in_flags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [5:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SAR  = 4'd7;
    localparam logic [3:0] OP_MULL = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;

    state_t                    state, state_nxt;
    logic                      accept, is_mul, mul_last, mul_done, mul_fit;
    logic [CNT_W-1:0]          cnt;
    logic signed [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]          mplier;
    logic                      mul_hi;
    logic [TAG_W-1:0]          mul_tag;
    logic [WIDTH+5:0]          alu_res;

    // Flag vector layout is {of, af, cf, zf, sf, pf}; pf is even parity of the low byte.
    function automatic logic [5:0] flags_of(input logic [WIDTH-1:0] v, input logic of,
                                            input logic af, input logic cf);
        return {of, af, cf, (v == '0), v[WIDTH-1], ~^v[7:0]};
    endfunction

    function automatic logic [WIDTH+5:0] alu_compute(input logic [3:0] op,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic [5:0] fl);
        logic [WIDTH:0]   ext;
        logic [4:0]       nib;
        logic [WIDTH-1:0] r;
        logic [SH_W-1:0]  sh;
        logic [5:0]       f;
        logic             of;
        ext = '0;
        nib = '0;
        r   = a;
        f   = fl;
        of  = 1'b0;
        sh  = b[SH_W-1:0];
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                nib = {1'b0, a[3:0]} + {1'b0, b[3:0]};
                r   = ext[WIDTH-1:0];
                of  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                f   = flags_of(r, of, nib[4], ext[WIDTH]);
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                nib = {1'b0, a[3:0]} - {1'b0, b[3:0]};
                r   = ext[WIDTH-1:0];
                of  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                f   = flags_of(r, of, nib[4], ext[WIDTH]);
            end
            OP_AND: begin r = a & b; f = flags_of(r, 1'b0, 1'b0, 1'b0); end
            OP_OR:  begin r = a | b; f = flags_of(r, 1'b0, 1'b0, 1'b0); end
            OP_XOR: begin r = a ^ b; f = flags_of(r, 1'b0, 1'b0, 1'b0); end
            // The extra bit of ext catches the last bit shifted out (carry).
            OP_SHL: if (sh != '0) begin
                ext = {1'b0, a} << sh;
                r   = ext[WIDTH-1:0];
                of  = (sh == SH_W'(1)) ? (r[WIDTH-1] ^ ext[WIDTH]) : 1'b0;
                f   = flags_of(r, of, 1'b0, ext[WIDTH]);
            end
            OP_SHR: if (sh != '0) begin
                ext = {a, 1'b0} >> sh;
                r   = ext[WIDTH:1];
                of  = (sh == SH_W'(1)) ? a[WIDTH-1] : 1'b0;
                f   = flags_of(r, of, 1'b0, ext[0]);
            end
            OP_SAR: if (sh != '0) begin
                ext = $signed({a, 1'b0}) >>> sh;
                r   = ext[WIDTH:1];
                f   = flags_of(r, 1'b0, 1'b0, ext[0]);
            end
            default: begin r = a; f = fl; end
        endcase
        return {f, r};
    endfunction

    assign in_ready = (state == IDLE) & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign is_mul   = (in_op == OP_MULL) | (in_op == OP_MULH);
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
    assign mul_done = (state == MUL) & mul_last;
    assign alu_res  = alu_compute(in_op, in_src0, in_src1, in_flags);

    // Multiplier MSB has negative weight, so the last partial product is subtracted.
    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) acc_nxt = mul_last ? acc - mcand : acc + mcand;
    end

    assign mul_fit = (&acc_nxt[2*WIDTH-1:WIDTH-1]) | ~(|acc_nxt[2*WIDTH-1:WIDTH-1]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_flags <= '0;
            out_tag   <= '0;
            cnt       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept && !is_mul) begin
                out_valid <= 1'b1;
                out_val   <= alu_res[WIDTH-1:0];
                out_flags <= alu_res[WIDTH+5:WIDTH];
                out_tag   <= in_tag;
            end else if (mul_done) begin
                out_valid <= 1'b1;
                out_val   <= mul_hi ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
                out_flags <= {~mul_fit, 1'b0, ~mul_fit, 3'b000};
                out_tag   <= mul_tag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == MUL) cnt <= mul_last ? '0 : cnt + CNT_W'(1);
            else              cnt <= '0;
        end
    end

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand   <= {{WIDTH{in_src0[WIDTH-1]}}, in_src0};
            mplier  <= in_src1;
            acc     <= '0;
            mul_hi  <= (in_op == OP_MULH);
            mul_tag <= in_tag;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand <<< 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: tb/tb_param_alu_unit.sv
// Scoreboard bench for param_alu_unit at WIDTH=8: stimulus pushes expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_param_alu_unit;
    localparam int W  = 8;
    localparam int TW = 4;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_SAR = 4'd7;
    localparam logic [3:0] OP_MULL = 4'd8, OP_MULH = 4'd9, OP_MOVE = 4'd10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [W-1:0]  in_src0 = '0;
    logic [W-1:0]  in_src1 = '0;
    logic [5:0]    in_flags = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_val;
    logic [5:0]    out_flags;
    logic [TW-1:0] out_tag;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [5:0]    flags;
        logic [W-1:0]  val;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   last_wait = 0;

    param_alu_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src0(in_src0), .in_src1(in_src1), .in_flags(in_flags), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
        .out_flags(out_flags), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a handshake at the coming edge is visible at this negedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: got tag %0d val 0x%0h expected no result",
                         out_tag, out_val);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("result_tag%0d", e.tag), {out_tag, out_flags, out_val}, e);
            end
        end
    end

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [5:0] fl, input logic [TW-1:0] tag,
                         input logic [W-1:0] ev, input logic [5:0] ef,
                         input bit expect_out, input int lat);
        int n;
        bit busy_ok;
        in_op = op; in_src0 = a; in_src1 = b; in_flags = fl; in_tag = tag; in_valid = 1'b1;
        last_wait = 0;
        @(negedge clk);
        while (!in_ready && last_wait < 40) begin
            last_wait++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL %s accept: got in_ready 0 for 40 cycles expected 1", name);
            in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        if (expect_out) exp_q.push_back({tag, ef, ev});
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (lat > 0) begin
            n = 1;
            busy_ok = 1'b1;
            @(negedge clk);
            while (!out_valid && n < 40) begin
                if (in_ready) busy_ok = 1'b0;
                n++;
                @(negedge clk);
            end
            check({name, "_latency"}, n, lat);
            if (lat > 1) check({name, "_busy_not_ready"}, busy_ok, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cnt_v;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_val",   out_val,   0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_tag",   out_tag,   0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        issue("add_ff_01", OP_ADD, 8'hFF, 8'h01, 6'h00, 4'd1, 8'h00, 6'h1D, 1, 1);
        check("first_accept_wait", last_wait, 0);
        issue("sub_00_01", OP_SUB, 8'h00, 8'h01, 6'h00, 4'd2, 8'hFF, 6'h1B, 1, 1);
        issue("sub_80_01", OP_SUB, 8'h80, 8'h01, 6'h00, 4'd3, 8'h7F, 6'h30, 1, 1);
        issue("add_7f_01", OP_ADD, 8'h7F, 8'h01, 6'h00, 4'd4, 8'h80, 6'h32, 1, 1);
        issue("and_f0_0f", OP_AND, 8'hF0, 8'h0F, 6'h3F, 4'd5, 8'h00, 6'h05, 1, 1);
        issue("or_80_01",  OP_OR,  8'h80, 8'h01, 6'h3F, 4'd6, 8'h81, 6'h03, 1, 1);
        issue("xor_a5_0f", OP_XOR, 8'hA5, 8'h0F, 6'h00, 4'd7, 8'hAA, 6'h03, 1, 1);
        issue("shl_81_1",  OP_SHL, 8'h81, 8'h01, 6'h00, 4'd8, 8'h02, 6'h28, 1, 1);
        issue("shr_81_1",  OP_SHR, 8'h81, 8'h01, 6'h00, 4'd9, 8'h40, 6'h28, 1, 1);
        issue("sar_80_3",  OP_SAR, 8'h80, 8'h03, 6'h00, 4'd10, 8'hF0, 6'h03, 1, 1);
        issue("shl_cnt8",  OP_SHL, 8'h5A, 8'h08, 6'h15, 4'd11, 8'h5A, 6'h15, 1, 1);
        issue("sar_80_f",  OP_SAR, 8'h80, 8'h0F, 6'h00, 4'd12, 8'hFF, 6'h03, 1, 1);
        issue("move_3c",   OP_MOVE, 8'h3C, 8'h99, 6'h2A, 4'd13, 8'h3C, 6'h2A, 1, 1);
        issue("resv_op13", 4'd13,  8'h77, 8'h01, 6'h11, 4'd14, 8'h77, 6'h11, 1, 1);

        issue("mull_ff_02", OP_MULL, 8'hFF, 8'h02, 6'h00, 4'd1, 8'hFE, 6'h00, 1, 9);
        issue("mulh_ff_02", OP_MULH, 8'hFF, 8'h02, 6'h00, 4'd2, 8'hFF, 6'h00, 1, 9);
        issue("mull_40_04", OP_MULL, 8'h40, 8'h04, 6'h3F, 4'd3, 8'h00, 6'h28, 1, 9);
        issue("mulh_40_04", OP_MULH, 8'h40, 8'h04, 6'h00, 4'd4, 8'h01, 6'h28, 1, 9);
        issue("mull_80_ff", OP_MULL, 8'h80, 8'hFF, 6'h00, 4'd5, 8'h80, 6'h28, 1, 9);
        issue("mull_03_fd", OP_MULL, 8'h03, 8'hFD, 6'h00, 4'd6, 8'hF7, 6'h00, 1, 9);
        issue("mulh_03_fd", OP_MULH, 8'h03, 8'hFD, 6'h00, 4'd7, 8'hFF, 6'h00, 1, 9);

        // Back-to-back ADDs with the consumer stalled for three cycles.
        out_ready = 1'b0;
        in_op = OP_ADD; in_src0 = 8'h10; in_src1 = 8'h20; in_flags = '0; in_tag = 4'd1;
        in_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_ready", in_ready, 1);
        exp_q.push_back({4'd1, 6'h01, 8'h30});
        @(posedge clk); #1;
        in_src0 = 8'h7F; in_src1 = 8'h01; in_tag = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_hold_valid", out_valid, 1);
            check("b2b_hold_val", {out_tag, out_flags, out_val}, {4'd1, 6'h01, 8'h30});
            check("b2b_stall_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_second_ready", in_ready, 1);
        exp_q.push_back({4'd2, 6'h32, 8'h80});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_valid", out_valid, 1);
        @(posedge clk); #1;

        // Flush drops a held result.
        out_ready = 1'b0;
        issue("and_flushed", OP_AND, 8'hFF, 8'h0F, 6'h00, 4'd9, 8'h00, 6'h00, 0, 0);
        @(negedge clk);
        check("flush_pre_valid", out_valid, 1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", in_ready, 0);
        @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_clears_valid", out_valid, 0);
        @(posedge clk); #1;

        // Flush on the fourth cycle of a multiply.
        issue("mul_flushed", OP_MULL, 8'h05, 8'h07, 6'h00, 4'd10, 8'h00, 6'h00, 0, 0);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("mul_flush_ready_low", in_ready, 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("mul_flush_ready_next", in_ready, 1);
        check("mul_flush_valid", out_valid, 0);
        cnt_v = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt_v++;
        end
        check("mul_flush_no_result", cnt_v, 0);
        @(posedge clk); #1;

        // Reset pulse in the middle of a multiply.
        issue("sub_pre_reset", OP_SUB, 8'h00, 8'h01, 6'h00, 4'd6, 8'hFF, 6'h1B, 1, 1);
        issue("mul_reset", OP_MULL, 8'h7F, 8'h7F, 6'h00, 4'd10, 8'h00, 6'h00, 0, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_val",   out_val,   0);
        check("mid_rst_flags", out_flags, 0);
        check("mid_rst_tag",   out_tag,   0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        issue("add_after_reset", OP_ADD, 8'h12, 8'h34, 6'h00, 4'd11, 8'h46, 6'h00, 1, 1);
        check("post_reset_accept_wait", last_wait, 0);
        cnt_v = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt_v++;
        end
        check("mul_reset_no_result", cnt_v, 0);

        cnt_v = 0;
        while (exp_q.size() != 0 && cnt_v < 50) begin
            @(negedge clk);
            cnt_v++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
